// File: rtl/byte_enabled_sdp_ram.sv
// Simple dual-port RAM, one write and one read port on one clock, with per-byte write enables.
// Each byte lane is its own narrow RAM so byte-enable writes map directly onto block RAM lanes.
module byte_enabled_sdp_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int BYTE_WIDTH = 8,
    parameter int BYTES      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          we,
    input  logic [BYTES-1:0]              be,
    input  logic [ADDR_WIDTH-1:0]         waddr,
    input  logic [BYTES*BYTE_WIDTH-1:0]   wdata,
    input  logic [ADDR_WIDTH-1:0]         raddr,
    output logic [BYTES*BYTE_WIDTH-1:0]   q
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            // Contents start at zero; reset only affects the output register, never storage.
            logic [BYTE_WIDTH-1:0] mem_reg [DEPTH] = '{default: '0};
            logic [BYTE_WIDTH-1:0] q_reg;

            always_ff @(posedge clk) begin
                if (rst_n && we && be[gi]) begin
                    mem_reg[waddr] <= wdata[gi*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end

            // Same-address read-during-write returns the pre-write byte (read-first).
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_reg <= '0;
                end else begin
                    q_reg <= mem_reg[raddr];
                end
            end

            assign q[gi*BYTE_WIDTH +: BYTE_WIDTH] = q_reg;
        end
    endgenerate

endmodule

// File: tb/tb_byte_enabled_sdp_ram.sv
// Scoreboard bench for byte_enabled_sdp_ram: expected read words are queued when a cycle is
// driven and compared one cycle later; directed constants back up the spec-defined scenarios.
module tb_byte_enabled_sdp_ram;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [3:0]  be;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic [7:0]  raddr;
    logic [31:0] q;

    logic [31:0] model [256];
    logic [31:0] exp_q [$];
    logic [31:0] last_q;
    int          n_cmp;
    int          n_err;

    byte_enabled_sdp_ram dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .be    (be),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    // Drive one clock of stimulus (called just after a falling edge), then compare q after the edge.
    task automatic cycle(input logic we_i, input logic [3:0] be_i, input logic [7:0] waddr_i,
                         input logic [31:0] wdata_i, input logic [7:0] raddr_i, input string tag);
        logic [31:0] w;
        we    = we_i;
        be    = be_i;
        waddr = waddr_i;
        wdata = wdata_i;
        raddr = raddr_i;
        exp_q.push_back(model[raddr_i]);
        if (we_i) begin
            w = model[waddr_i];
            for (int i = 0; i < 4; i++)
                if (be_i[i]) w[i*8 +: 8] = wdata_i[i*8 +: 8];
            model[waddr_i] = w;
        end
        @(posedge clk);
        @(negedge clk);
        last_q = q;
        if (exp_q.size() == 0) begin
            check({tag, "_noexp"}, last_q, 32'hxxxxxxxx);
        end else begin
            check(tag, last_q, exp_q.pop_front());
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) model[i] = 32'h0;
        rst_n = 1'b0;
        we = 1'b0; be = 4'h0; waddr = 8'h0; wdata = 32'h0; raddr = 8'h0;
        repeat (2) @(negedge clk);
        check("rst_q", q, 32'h0);
        rst_n = 1'b1;

        // 1: reads of fresh storage
        for (int a = 0; a < 3; a++) cycle(1'b0, 4'h0, 8'h0, 32'h0, 8'(a), "init_rd");

        // 2: lane-0-only writes, then read back
        for (int a = 0; a < 3; a++) cycle(1'b1, 4'b0001, 8'(a), 32'hFFFF_FFFF, 8'd10, "lane_wr");
        for (int a = 0; a < 3; a++) begin
            cycle(1'b0, 4'h0, 8'h0, 32'h0, 8'(a), "lane_rd");
            check("lane_const", last_q, 32'h0000_00FF);
        end

        // 3: lane merge and be=0000 no-op
        cycle(1'b1, 4'b1111, 8'd5, 32'h1122_3344, 8'd9, "merge_w1");
        cycle(1'b1, 4'b0100, 8'd5, 32'hAABB_CCDD, 8'd9, "merge_w2");
        cycle(1'b0, 4'h0, 8'h0, 32'h0, 8'd5, "merge_rd");
        check("merge_const", last_q, 32'h11BB_3344);
        cycle(1'b1, 4'b0000, 8'd5, 32'h0000_0000, 8'd9, "noop_w");
        cycle(1'b0, 4'hF, 8'd5, 32'h0, 8'd5, "noop_rd");
        check("noop_const", last_q, 32'h11BB_3344);

        // 4: read-during-write on the same address returns the old word
        cycle(1'b1, 4'b1111, 8'd7, 32'hDEAD_BEEF, 8'd7, "rdw_old");
        check("rdw_old_const", last_q, 32'h0);
        cycle(1'b0, 4'h0, 8'h0, 32'h0, 8'd7, "rdw_new");
        check("rdw_new_const", last_q, 32'hDEAD_BEEF);

        // 5: async reset between edges while a write is being held
        cycle(1'b0, 4'h0, 8'h0, 32'h0, 8'd0, "pre_rst");
        we = 1'b1; be = 4'hF; waddr = 8'd0; wdata = 32'h1234_5678; raddr = 8'd0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", q, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hold", q, 32'h0);
        we = 1'b0;
        rst_n = 1'b1;
        cycle(1'b0, 4'h0, 8'h0, 32'h0, 8'd0, "post_rst");
        check("post_rst_const", last_q, 32'h0000_00FF);

        // Different-address read/write traffic
        for (int i = 0; i < 60; i++) begin
            logic [7:0] wa, ra;
            wa = 8'($urandom_range(0, 15));
            ra = 8'($urandom_range(0, 15));
            if (ra == wa) ra = ra ^ 8'h1;
            cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), wa, $urandom, ra, "rand");
        end

        // 6: full address sweep
        for (int a = 0; a < 256; a++)
            cycle(1'b1, 4'hF, 8'(a), {24'h0, 8'(a)} ^ 32'hA5A5_A5A5, 8'(255 - a), "sweep_w");
        for (int a = 0; a < 256; a++) cycle(1'b0, 4'h0, 8'h0, 32'h0, 8'(a), "sweep_rd");
        cycle(1'b0, 4'h0, 8'h0, 32'h0, 8'd0, "sweep_a0");
        check("sweep_a0_const", last_q, 32'hA5A5_A5A5);
        cycle(1'b0, 4'h0, 8'h0, 32'h0, 8'd255, "sweep_a255");
        check("sweep_a255_const", last_q, 32'hA5A5_A55A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
